// File: rtl/dbus_sram_responder_if.sv
// dbus_sram_responder_if: data-bus request/response signals between the memory stage and the data SRAM.
interface dbus_sram_responder_if;
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] resp_data;
    modport master (output valid, addr, size, strobe, data, input addr_ok, data_ok, resp_data);
    modport slave  (input valid, addr, size, strobe, data, output addr_ok, data_ok, resp_data);
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: fixed-latency data-bus SRAM responder with byte-strobe writes.
// Optional alignment checking with DBUS_MISALIGN_CHECK_EN.
module dbus_sram_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input logic clk,
    input logic reset,
    dbus_sram_responder_if.slave dbus
`ifdef DBUS_MISALIGN_CHECK_EN
    ,
    output logic misalign
`endif
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [63:0] mem [MEM_WORDS];
    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [63:0] addr_q, data_q, rdata_q;
    logic [7:0]  strobe_q;
    logic [63:0] cur_addr, off;
    logic [7:0]  cur_strobe;
    logic [IW-1:0] idx;
    logic        in_range, cur_bad, ok, enter_resp;

`ifdef DBUS_MISALIGN_CHECK_EN
    logic mis_q;
    function automatic logic misaligned(input logic [2:0] s, input logic [63:0] a);
        return (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0) || (s == 3'd3 && a[2:0] != 3'd0);
    endfunction
    assign cur_bad  = (state == IDLE) ? misaligned(dbus.size, dbus.addr) : mis_q;
    assign misalign = (state == RESP) && mis_q;
`else
    assign cur_bad = 1'b0;
`endif

    // In IDLE the access is still on the bus; afterwards it lives in the latches.
    always_comb begin
        cur_addr   = (state == IDLE) ? dbus.addr : addr_q;
        cur_strobe = (state == IDLE) ? dbus.strobe : strobe_q;
        off        = cur_addr - BASE_ADDR;
        in_range   = (cur_addr >= BASE_ADDR) && (off < 64'(MEM_WORDS) * 64'd8);
        idx        = IW'(off >> 3);
        ok         = in_range && !cur_bad;
        enter_resp = (state == IDLE && dbus.valid && LATENCY == 1) || (state == BUSY && cnt == 4'd1);
    end

    assign dbus.addr_ok   = (state == IDLE) && dbus.valid;
    assign dbus.data_ok   = (state == RESP);
    assign dbus.resp_data = (state == RESP) ? rdata_q : 64'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= 64'h0;
            data_q   <= 64'h0;
            strobe_q <= 8'h0;
            rdata_q  <= 64'h0;
`ifdef DBUS_MISALIGN_CHECK_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            if (enter_resp)
                rdata_q <= (ok && cur_strobe == 8'h0) ? mem[idx] : 64'h0;
            if (state == IDLE && dbus.valid) begin
                addr_q   <= dbus.addr;
                data_q   <= dbus.data;
                strobe_q <= dbus.strobe;
                cnt      <= 4'(LATENCY - 1);
                state    <= (LATENCY > 1) ? BUSY : RESP;
`ifdef DBUS_MISALIGN_CHECK_EN
                mis_q    <= misaligned(dbus.size, dbus.addr);
`endif
            end else if (state == BUSY) begin
                cnt   <= cnt - 4'd1;
                state <= (cnt == 4'd1) ? RESP : BUSY;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end

    // Write commits on the edge leaving RESP, so a following read always sees it.
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && strobe_q != 8'h0 && ok)
            for (int i = 0; i < 8; i++)
                if (strobe_q[i])
                    mem[idx][8*i +: 8] <= data_q[8*i +: 8];
    end
endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: scoreboard bench for dbus_sram_responder (LATENCY 2, plus 1 and 15 period checks).
module tb_dbus_sram_responder;
    localparam logic [63:0] B = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_sram_responder_if dif ();
    dbus_sram_responder_if dif1 ();
    dbus_sram_responder_if dif15 ();

`ifdef DBUS_MISALIGN_CHECK_EN
    logic mis, mis1, mis15;
    dbus_sram_responder #(.LATENCY(2))  dut   (.clk(clk), .reset(reset), .dbus(dif.slave),   .misalign(mis));
    dbus_sram_responder #(.LATENCY(1))  dut1  (.clk(clk), .reset(reset), .dbus(dif1.slave),  .misalign(mis1));
    dbus_sram_responder #(.LATENCY(15)) dut15 (.clk(clk), .reset(reset), .dbus(dif15.slave), .misalign(mis15));
`else
    dbus_sram_responder #(.LATENCY(2))  dut   (.clk(clk), .reset(reset), .dbus(dif.slave));
    dbus_sram_responder #(.LATENCY(1))  dut1  (.clk(clk), .reset(reset), .dbus(dif1.slave));
    dbus_sram_responder #(.LATENCY(15)) dut15 (.clk(clk), .reset(reset), .dbus(dif15.slave));
`endif

    logic [63:0] exp_q [$];
    bit          mexp_q [$];
    int          lat_q [$];
    int          p1 [$];
    int          p15 [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per data_ok and checks latency and zero data elsewhere.
    always @(negedge clk) begin
        if (reset) begin
            lat_q.delete();
        end else begin
            if (dif.addr_ok) lat_q.push_back(cyc + 2);
            if (dif.data_ok) begin
                if (exp_q.size() == 0 || lat_q.size() == 0) begin
                    chk("unexpected_data_ok", 1'b1, 1'b0);
                end else begin
                    chk("resp_data", dif.resp_data, exp_q.pop_front());
                    chk("latency", 64'(cyc), 64'(lat_q.pop_front()));
`ifdef DBUS_MISALIGN_CHECK_EN
                    chk("misalign", mis, mexp_q.pop_front());
`endif
                end
            end else begin
                chk("idle_data_zero", dif.resp_data, 64'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            p1.delete();
            p15.delete();
        end else begin
            if (dif1.data_ok) p1.push_back(cyc);
            if (dif15.data_ok) p15.push_back(cyc);
        end
    end

    task automatic txn(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] s,
                       input logic [63:0] d, input logic [63:0] e, input bit m, input bit abort);
        bit got = 0;
        @(posedge clk); #1;
        dif.valid = 1'b1; dif.addr = a; dif.size = sz; dif.strobe = s; dif.data = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = dif.addr_ok;
        end
        chk("accept", got, 1'b1);
        if (got && !abort) begin
            exp_q.push_back(e);
            mexp_q.push_back(m);
        end
        @(posedge clk); #1;
        dif.valid = 1'b0;
        if (abort) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (4) @(posedge clk);
        end else if (got) begin
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = dif.data_ok;
            end
            chk("data_ok_seen", got, 1'b1);
        end
    endtask

    initial begin
        dif.valid = 0; dif.addr = 0; dif.size = 0; dif.strobe = 0; dif.data = 0;
        dif1.valid = 1; dif1.addr = B; dif1.size = 3; dif1.strobe = 0; dif1.data = 0;
        dif15.valid = 1; dif15.addr = B; dif15.size = 3; dif15.strobe = 0; dif15.data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr_ok", dif.addr_ok, 1'b0);
        chk("reset_data_ok", dif.data_ok, 1'b0);
        chk("reset_resp_data", dif.resp_data, 64'h0);
        reset = 1'b0;
        txn(B + 8,      3, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0, 0);
        txn(B + 8,      3, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 0, 0);
        txn(B + 8,      3, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, 64'h0, 0, 0);
        txn(B + 8,      3, 8'h00, 64'h0, 64'h1122_3344_AAAA_BBBB, 0, 0);
        txn(B,          3, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
        txn(B + 'h2000, 3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 0, 0);
        txn(B + 'h2000, 3, 8'h00, 64'h0, 64'h0, 0, 0);
        txn(B,          3, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0);
        txn(B - 8,      3, 8'h00, 64'h0, 64'h0, 0, 0);
        txn(B + 'h1FF8, 3, 8'hFF, 64'hCAFE_F00D_1234_5678, 64'h0, 0, 0);
        txn(B + 'h1FF8, 3, 8'h00, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 0);
        txn(B + 16,     3, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 0, 0);
        txn(B + 16,     3, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 0, 1);
        txn(B + 16,     3, 8'h00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 0, 0);
        txn(B + 8,      3, 8'h00, 64'h0, 64'h1122_3344_AAAA_BBBB, 0, 0);
`ifdef DBUS_MISALIGN_CHECK_EN
        txn(B + 4,      3, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0);
        txn(B,          3, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0);
`endif
        for (int i = 0; i < 200 && p15.size() < 4; i++) @(posedge clk);
        chk("p1_count", 64'(p1.size() >= 4), 64'd1);
        chk("p15_count", 64'(p15.size() >= 4), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (p1.size() > i + 1) chk("period_lat1", 64'(p1[i+1] - p1[i]), 64'd2);
            if (p15.size() > i + 1) chk("period_lat15", 64'(p15[i+1] - p15[i]), 64'd16);
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
